// File: rtl/kgp_run_controller.sv
// Run controller for the KGP_RISC core: sequences core reset/enable, detects halt
// (PC stable) or cycle-budget timeout, then freezes the core and latches its final PC/Result.
module kgp_run_controller #(
    parameter int unsigned RESET_CYCLES  = 1,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_CYCLES    = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [31:0] PCValue,
    input  logic [31:0] Result,
    output logic        cpu_reset,
    output logic        cpu_ena,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] final_pc,
    output logic [31:0] final_result,
    output logic [31:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET_CPU,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_cpu_reset, w_cpu_reset_next;
    logic        r_cpu_ena, w_cpu_ena_next;
    logic        r_busy, w_busy_next;
    logic        r_done, w_done_next;
    logic        r_timeout, w_timeout_next;
    logic [31:0] r_final_pc, w_final_pc_next;
    logic [31:0] r_final_result, w_final_result_next;
    logic [31:0] r_cycle_count, w_cycle_count_next;
    logic [31:0] r_rst_cnt, w_rst_cnt_next;
    logic [31:0] r_stable_cnt, w_stable_cnt_next;
    logic [31:0] r_prev_pc, w_prev_pc_next;
    logic [31:0] w_cnt_inc;
    logic [31:0] w_rst_inc;
    logic        w_halt;
    logic        w_budget_out;

    assign w_cnt_inc = (r_cycle_count == '1) ? r_cycle_count : r_cycle_count + 32'd1;
    assign w_rst_inc = r_rst_cnt + 32'd1;

    always_comb begin
        w_state_next        = r_state;
        w_cpu_reset_next    = r_cpu_reset;
        w_cpu_ena_next      = r_cpu_ena;
        w_busy_next         = r_busy;
        w_done_next         = r_done;
        w_timeout_next      = r_timeout;
        w_final_pc_next     = r_final_pc;
        w_final_result_next = r_final_result;
        w_cycle_count_next  = r_cycle_count;
        w_rst_cnt_next      = r_rst_cnt;
        w_stable_cnt_next   = r_stable_cnt;
        w_prev_pc_next      = r_prev_pc;
        w_halt              = 1'b0;
        w_budget_out        = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next       = S_RESET_CPU;
                    w_cpu_reset_next   = 1'b1;
                    w_cpu_ena_next     = 1'b1;
                    w_busy_next        = 1'b1;
                    w_done_next        = 1'b0;
                    w_timeout_next     = 1'b0;
                    w_cycle_count_next = '0;
                    w_rst_cnt_next     = '0;
                end
            end

            S_RESET_CPU: begin
                w_rst_cnt_next = w_rst_inc;
                if (w_rst_inc >= 32'(RESET_CYCLES)) begin
                    w_state_next      = S_RUN;
                    w_cpu_reset_next  = 1'b0;
                    w_stable_cnt_next = '0;
                end
            end

            S_RUN: begin
                w_cycle_count_next = w_cnt_inc;
                w_prev_pc_next     = PCValue;
                // prev_pc is stale from an earlier run on the first RUN cycle
                if (r_cycle_count == '0)
                    w_stable_cnt_next = '0;
                else if (PCValue == r_prev_pc)
                    w_stable_cnt_next = r_stable_cnt + 32'd1;
                else
                    w_stable_cnt_next = '0;

                w_halt       = (w_stable_cnt_next == 32'(STABLE_CYCLES));
                w_budget_out = (w_cnt_inc == 32'(MAX_CYCLES));

                if (w_halt || w_budget_out) begin
                    w_state_next        = S_DONE;
                    w_final_pc_next     = PCValue;
                    w_final_result_next = Result;
                    w_cpu_ena_next      = 1'b0;
                    w_busy_next         = 1'b0;
                    w_done_next         = 1'b1;
                    w_timeout_next      = !w_halt;
                end
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_cpu_reset    <= 1'b0;
            r_cpu_ena      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_final_pc     <= '0;
            r_final_result <= '0;
            r_cycle_count  <= '0;
            r_rst_cnt      <= '0;
            r_stable_cnt   <= '0;
            r_prev_pc      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cpu_reset    <= w_cpu_reset_next;
            r_cpu_ena      <= w_cpu_ena_next;
            r_busy         <= w_busy_next;
            r_done         <= w_done_next;
            r_timeout      <= w_timeout_next;
            r_final_pc     <= w_final_pc_next;
            r_final_result <= w_final_result_next;
            r_cycle_count  <= w_cycle_count_next;
            r_rst_cnt      <= w_rst_cnt_next;
            r_stable_cnt   <= w_stable_cnt_next;
            r_prev_pc      <= w_prev_pc_next;
        end
    end

    assign cpu_reset    = r_cpu_reset;
    assign cpu_ena      = r_cpu_ena;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign final_pc     = r_final_pc;
    assign final_result = r_final_result;
    assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_kgp_run_controller.sv
// Bench for kgp_run_controller: directed and randomized runs against a sequence-level
// reference that finds the halt point as the first window of STABLE_CYCLES+1 equal PCs.
module tb_kgp_run_controller;

    localparam int RC = 1;
    localparam int SC = 4;
    localparam int MC = 60;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [31:0] PCValue;
    logic [31:0] Result;
    logic        cpu_reset, cpu_ena, busy, done, timeout;
    logic [31:0] final_pc, final_result, cycle_count;

    kgp_run_controller #(
        .RESET_CYCLES (RC),
        .STABLE_CYCLES(SC),
        .MAX_CYCLES   (MC)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .PCValue     (PCValue),
        .Result      (Result),
        .cpu_reset   (cpu_reset),
        .cpu_ena     (cpu_ena),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .final_pc    (final_pc),
        .final_result(final_result),
        .cycle_count (cycle_count)
    );

    always #5 Clk = ~Clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pcs [1:MC];
    logic [31:0] res [1:MC];
    logic [31:0] exp_fpc  = '0;
    logic [31:0] exp_fres = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
        chk({tag, ".cpu_ena"},   {31'd0, cpu_ena},   32'd0);
        chk({tag, ".busy"},      {31'd0, busy},      32'd0);
        chk({tag, ".done"},      {31'd0, done},      32'd0);
        chk({tag, ".timeout"},   {31'd0, timeout},   32'd0);
        chk({tag, ".final_pc"},  final_pc,           32'd0);
        chk({tag, ".final_res"}, final_result,       32'd0);
        chk({tag, ".cycles"},    cycle_count,        32'd0);
    endtask

    // Halt is the first RUN cycle k whose PC equals the SC preceding ones (all within
    // this run); otherwise the budget runs out at MC. A halt on cycle MC still wins.
    task automatic model(output int k_end, output bit to);
        k_end = MC;
        to    = 1'b1;
        for (int k = SC + 1; k <= MC; k++) begin
            bit same = 1'b1;
            for (int j = k - SC; j < k; j++)
                if (pcs[j] !== pcs[k]) same = 1'b0;
            if (same) begin
                k_end = k;
                to    = 1'b0;
                return;
            end
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        PCValue = $urandom;
        Result  = $urandom;
        step();
        start = 1'b0;
        chk("start.cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("start.cpu_ena",   {31'd0, cpu_ena},   32'd1);
        chk("start.busy",      {31'd0, busy},      32'd1);
        chk("start.done",      {31'd0, done},      32'd0);
        chk("start.timeout",   {31'd0, timeout},   32'd0);
        chk("start.cycles",    cycle_count,        32'd0);
        chk("start.final_pc",  final_pc,           exp_fpc);
        chk("start.final_res", final_result,       exp_fres);
        for (int i = 1; i < RC; i++) begin
            step();
            chk("rst.cpu_reset", {31'd0, cpu_reset}, 32'd1);
        end
        step();
        chk("run0.cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("run0.cpu_ena",   {31'd0, cpu_ena},   32'd1);
        chk("run0.busy",      {31'd0, busy},      32'd1);
    endtask

    // Core model: PC/Result for RUN cycle k come from pcs[k]/res[k]; start toggles randomly
    // while busy and must be ignored.
    task automatic run_body(input int reset_at);
        int k_end;
        bit to;
        model(k_end, to);
        for (int k = 1; k <= MC; k++) begin
            PCValue = pcs[k];
            Result  = res[k];
            start   = 1'($urandom);
            if (k == reset_at) Reset = 1'b1;
            step();
            start = 1'b0;
            if (k == reset_at) begin
                Reset = 1'b0;
                chk_all_zero("midreset");
                exp_fpc  = '0;
                exp_fres = '0;
                step();
                chk("midreset.idle.busy", {31'd0, busy}, 32'd0);
                return;
            end
            if (k < k_end) begin
                chk("run.busy",    {31'd0, busy},    32'd1);
                chk("run.done",    {31'd0, done},    32'd0);
                chk("run.cpu_ena", {31'd0, cpu_ena}, 32'd1);
                chk("run.cycles",  cycle_count,      32'(k));
            end else begin
                chk("end.done",      {31'd0, done},      32'd1);
                chk("end.busy",      {31'd0, busy},      32'd0);
                chk("end.cpu_ena",   {31'd0, cpu_ena},   32'd0);
                chk("end.cpu_reset", {31'd0, cpu_reset}, 32'd0);
                chk("end.timeout",   {31'd0, timeout},   {31'd0, to});
                chk("end.cycles",    cycle_count,        32'(k));
                chk("end.final_pc",  final_pc,           pcs[k]);
                chk("end.final_res", final_result,       res[k]);
                exp_fpc  = pcs[k];
                exp_fres = res[k];
                PCValue = $urandom;
                Result  = $urandom;
                step();
                chk("hold.done",     {31'd0, done},    32'd1);
                chk("hold.timeout",  {31'd0, timeout}, {31'd0, to});
                chk("hold.cycles",   cycle_count,      32'(k));
                chk("hold.final_pc", final_pc,         exp_fpc);
                return;
            end
        end
        chk("run.no_end", 32'd0, 32'd1);
    endtask

    task automatic fill_plan();
        for (int k = 1; k <= MC; k++) begin
            pcs[k] = (k <= 10) ? 32'((k - 1) * 4) : 32'h28;
            res[k] = 32'h37;
        end
    endtask

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        PCValue = '0;
        Result  = '0;
        step();
        step();
        Reset = 1'b0;
        chk_all_zero("reset");
        step();
        chk("idle.busy", {31'd0, busy}, 32'd0);

        // program halting at 0x28 on RUN cycle 15
        fill_plan();
        start_run();
        run_body(0);
        chk("plan.final_pc", final_pc, 32'h28);
        chk("plan.cycles",   cycle_count, 32'd15);

        // restart from DONE; PC never settles -> timeout on cycle MC
        for (int k = 1; k <= MC; k++) begin
            pcs[k] = 32'h1000 + 32'(k * 4);
            res[k] = $urandom;
        end
        start_run();
        run_body(0);

        // fourth equal comparison lands exactly on the budget cycle
        for (int k = 1; k <= MC; k++) begin
            pcs[k] = (k <= MC - SC) ? 32'(k * 4) : 32'((MC - SC) * 4);
            res[k] = $urandom;
        end
        start_run();
        run_body(0);
        chk("edge.timeout", {31'd0, timeout}, 32'd0);

        // controller reset on RUN cycle 7
        fill_plan();
        start_run();
        run_body(7);

        for (int r = 0; r < 8; r++) begin
            logic [31:0] v;
            v = $urandom;
            for (int k = 1; k <= MC; k++) begin
                if ($urandom_range(0, 99) >= 72) v = 32'($urandom_range(0, 3) * 4);
                pcs[k] = v;
                res[k] = $urandom;
            end
            start_run();
            run_body(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
